// File: rtl/lstm_cell_state.sv
`default_nettype none
// ============================================================================
// Module   : lstm_cell_state
// Purpose  : LSTM cell-state update c = sat(f*c_prev + i*g) in Q4.12, with a
//            two-stage pipeline and a per-element recurrent state store.
// Revision : 1.0
// ============================================================================
module lstm_cell_state #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 12,
   parameter int VEC_LEN    = 8,
   parameter int IDX_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_state,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] f_gate,
   input  logic [DATA_WIDTH-1:0] i_gate,
   input  logic [DATA_WIDTH-1:0] g_cand,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] c_out,
   output logic [IDX_WIDTH-1:0]  out_idx,
   output logic                  out_last,
   output logic [15:0]           step_count
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(VEC_LEN - 1);
   localparam logic signed [PW:0] C_HALF =
      {{(PW - FRAC_BITS + 1){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
   localparam logic signed [PW:0] C_MAX =
      {{(DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [PW:0] C_MIN =
      {{(DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

   logic [DATA_WIDTH-1:0] state_q [VEC_LEN];
   logic [DATA_WIDTH-1:0] state_d [VEC_LEN];
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic                  s1_valid_q, s1_valid_d;
   logic signed [PW-1:0]  p1_q, p1_d;
   logic signed [PW-1:0]  p2_q, p2_d;
   logic [IDX_WIDTH-1:0]  s1_idx_q, s1_idx_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] c_out_q, c_out_d;
   logic [IDX_WIDTH-1:0]  out_idx_q, out_idx_d;
   logic                  out_last_q, out_last_d;
   logic [15:0]           step_q, step_d;

   logic                  w_advance;
   logic                  w_accept;
   logic signed [PW-1:0]  w_f_ext, w_c_ext, w_i_ext, w_g_ext;
   logic signed [PW:0]    w_sum, w_rnd, w_shr;
   logic [DATA_WIDTH-1:0] w_sat;

   assign w_advance  = !out_valid_q || out_ready;
   assign in_ready   = w_advance && !clear_state;
   assign w_accept   = in_valid && in_ready;

   assign out_valid  = out_valid_q;
   assign c_out      = c_out_q;
   assign out_idx    = out_idx_q;
   assign out_last   = out_last_q;
   assign step_count = step_q;

   // Sign-extend operands so the products are formed at full 2*DATA_WIDTH width.
   always_comb begin
      w_f_ext = {{DATA_WIDTH{f_gate[DATA_WIDTH-1]}}, f_gate};
      w_c_ext = {{DATA_WIDTH{state_q[idx_q][DATA_WIDTH-1]}}, state_q[idx_q]};
      w_i_ext = {{DATA_WIDTH{i_gate[DATA_WIDTH-1]}}, i_gate};
      w_g_ext = {{DATA_WIDTH{g_cand[DATA_WIDTH-1]}}, g_cand};
   end

   // Round half up, arithmetic shift back to Q4.12, then clamp to the word range.
   always_comb begin
      w_sum = {p1_q[PW-1], p1_q} + {p2_q[PW-1], p2_q};
      w_rnd = w_sum + C_HALF;
      w_shr = w_rnd >>> FRAC_BITS;
      if (w_shr > C_MAX) begin
         w_sat = C_MAX[DATA_WIDTH-1:0];
      end else if (w_shr < C_MIN) begin
         w_sat = C_MIN[DATA_WIDTH-1:0];
      end else begin
         w_sat = w_shr[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      s1_valid_d  = s1_valid_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      s1_idx_d    = s1_idx_q;
      out_valid_d = out_valid_q;
      c_out_d     = c_out_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      step_d      = step_q;

      if (out_valid_q && out_ready && out_last_q) begin
         step_d = step_q + 16'd1;
      end

      if (clear_state) begin
         idx_d       = '0;
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         for (int k = 0; k < VEC_LEN; k++) begin
            state_d[k] = '0;
         end
      end else if (w_advance) begin
         s1_valid_d = w_accept;
         if (w_accept) begin
            p1_d     = w_f_ext * w_c_ext;
            p2_d     = w_i_ext * w_g_ext;
            s1_idx_d = idx_q;
            idx_d    = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
         end
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            c_out_d           = w_sat;
            out_idx_d         = s1_idx_q;
            out_last_d        = (s1_idx_q == C_LAST_IDX);
            state_d[s1_idx_q] = w_sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < VEC_LEN; k++) begin
            state_q[k] <= '0;
         end
         idx_q       <= '0;
         s1_valid_q  <= 1'b0;
         p1_q        <= '0;
         p2_q        <= '0;
         s1_idx_q    <= '0;
         out_valid_q <= 1'b0;
         c_out_q     <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         step_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         s1_valid_q  <= s1_valid_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         s1_idx_q    <= s1_idx_d;
         out_valid_q <= out_valid_d;
         c_out_q     <= c_out_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         step_q      <= step_d;
      end
   end

endmodule
`default_nettype wire
